// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving the direction select of a downstream N_CH:1 data mux
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   req_i        per-source level request
//   ready_i      consumer accepts the current selection while valid_o=1
//   valid_o      direction_o/grant_o hold a valid grant
//   direction_o  index of the granted source (mux select)
//   grant_o      one-hot grant, zero while valid_o=0
//   lock_i       burst lock, only when MUX_RR_ARBITER_LOCK_EN is defined
module mux_rr_arbiter #(
    parameter int N_CH = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_CH-1:0]   req_i,
    input  logic              ready_i,
`ifdef MUX_RR_ARBITER_LOCK_EN
    input  logic              lock_i,
`endif
    output logic              valid_o,
    output logic [SEL_W-1:0]  direction_o,
    output logic [N_CH-1:0]   grant_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n, base, win, sel, dir_n;
    logic [N_CH-1:0] grant_n;
    logic keep;
    assign valid_o = (state == GRANT);
`ifdef MUX_RR_ARBITER_LOCK_EN
    assign keep = (state == GRANT) && lock_i && req_i[direction_o];
`else
    assign keep = 1'b0;
`endif
    // during GRANT the search starts after the current owner, which becomes ptr at handshake
    assign base = (state == GRANT) ? direction_o : ptr;
    // descending scan so the nearest requester after base wins
    always_comb begin
        win = base;
        for (int k = N_CH; k >= 1; k--)
            if (req_i[SEL_W'(int'(base) + k)]) win = SEL_W'(int'(base) + k);
    end
    assign sel = keep ? direction_o : win;
    always_comb begin
        state_n = state;
        dir_n   = direction_o;
        grant_n = grant_o;
        ptr_n   = ptr;
        if (state == IDLE) begin
            if (|req_i) begin
                state_n = GRANT;
                dir_n   = sel;
                grant_n = N_CH'(1) << sel;
            end
        end else if (ready_i) begin
            ptr_n = keep ? ptr : direction_o;
            if (|req_i) begin
                dir_n   = sel;
                grant_n = N_CH'(1) << sel;
            end else begin
                state_n = IDLE;
                grant_n = '0;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            direction_o <= '0;
            grant_o     <= '0;
            ptr         <= SEL_W'(N_CH - 1);
        end else begin
            state       <= state_n;
            direction_o <= dir_n;
            grant_o     <= grant_n;
            ptr         <= ptr_n;
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scoreboard bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic ready_i = 1'b0;
    logic lock_i = 1'b0;
    logic [3:0] req_i = '0;
    logic valid_o;
    logic [1:0] direction_o;
    logic [3:0] grant_o;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    typedef struct {
        int         c;
        logic       v;
        logic       cd;
        logic [1:0] d;
        string      nm;
    } exp_t;
    exp_t q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    mux_rr_arbiter dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .req_i(req_i),
        .ready_i(ready_i),
`ifdef MUX_RR_ARBITER_LOCK_EN
        .lock_i(lock_i),
`endif
        .valid_o(valid_o),
        .direction_o(direction_o),
        .grant_o(grant_o)
    );
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            exp_t e;
            logic [3:0] eg;
            e = q.pop_front();
            eg = e.v ? (4'd1 << e.d) : 4'd0;
            tests++;
            if (e.c != cyc || valid_o !== e.v || grant_o !== eg || (e.cd && direction_o !== e.d)) begin
                fails++;
                $display("FAIL %s cyc=%0d: got valid=%0b dir=%0d grant=%b, expected valid=%0b dir=%0d grant=%b",
                         e.nm, cyc, valid_o, direction_o, grant_o, e.v, e.d, eg);
            end
        end
    end
    task automatic step(input logic r, input logic [3:0] rq, input logic rd, input logic lk,
                        input logic ev, input logic [1:0] ed, input string nm);
        exp_t e;
        rst_i = r;
        req_i = rq;
        ready_i = rd;
        lock_i = lk;
        e = '{cyc + 1, ev, ev | r, ed, nm};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    initial begin
        @(posedge clk);
        #1;
        repeat (3) step(1, 4'b1111, 1, 0, 0, 0, "reset");
        step(0, 4'b1111, 1, 0, 1, 0, "fair0");
        step(0, 4'b1111, 1, 0, 1, 1, "fair1");
        step(0, 4'b1111, 1, 0, 1, 2, "fair2");
        step(0, 4'b1111, 1, 0, 1, 3, "fair3");
        step(0, 4'b1111, 1, 0, 1, 0, "fair_wrap");
        step(0, 4'b1111, 1, 0, 1, 1, "fair5");
        repeat (3) step(0, 4'b0100, 1, 0, 1, 2, "single");
        step(0, 4'b1001, 1, 0, 1, 3, "wrap_pair3");
        step(0, 4'b1001, 1, 0, 1, 0, "wrap_pair0");
        step(1, 4'b0000, 0, 0, 0, 0, "reset_pre_bp");
        step(0, 4'b1010, 0, 0, 1, 1, "bp_grant");
        step(0, 4'b1010, 0, 0, 1, 1, "bp_hold");
        step(0, 4'b0100, 0, 0, 1, 1, "bp_hold_reqchg");
        step(0, 4'b0000, 0, 0, 1, 1, "bp_hold_noreq");
        step(0, 4'b1010, 0, 0, 1, 1, "bp_hold");
        step(0, 4'b1010, 1, 0, 1, 3, "bp_release");
        step(0, 4'b0001, 1, 0, 1, 0, "drop_grant0");
        step(0, 4'b0000, 0, 0, 1, 0, "drop_held");
        step(0, 4'b0000, 0, 0, 1, 0, "drop_held");
        step(0, 4'b0000, 1, 0, 0, 0, "drop_idle");
        step(0, 4'b0000, 1, 0, 0, 0, "idle_stay");
        step(0, 4'b0110, 1, 0, 1, 1, "idle_to_grant");
        step(0, 4'b0110, 0, 0, 1, 1, "pre_rst_hold");
        step(1, 4'b0110, 0, 0, 0, 0, "midop_reset");
        step(0, 4'b1111, 1, 0, 1, 0, "restart_ch0");
        step(0, 4'b1111, 1, 0, 1, 1, "restart_ch1");
`ifdef MUX_RR_ARBITER_LOCK_EN
        step(1, 4'b0000, 1, 0, 0, 0, "lock_reset");
        step(0, 4'b0011, 1, 0, 1, 0, "lock_first");
        step(0, 4'b0011, 1, 1, 1, 0, "lock_keep");
        step(0, 4'b0011, 1, 1, 1, 0, "lock_keep");
        step(0, 4'b0011, 1, 0, 1, 1, "lock_release");
        step(0, 4'b0001, 1, 1, 1, 0, "lock_owner_low");
`endif
        step(0, 4'b0000, 1, 0, 0, 0, "final_idle");
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
